// File: rtl/blood_alarm_pkg.sv
// -----------------------------------------------------------------------------
// blood_alarm_pkg
// Shared types and helpers for the blood alarm controller:
//   state_e   - controller FSM state (NORMAL=0, SUSPECT=1, ALARM=2, HOLDOFF=3)
//   PH_W      - width of the pH code
//   TYPE_W    - width of the blood type code
//   sat_inc() - saturating increment for a counter of up to 32 bits
// -----------------------------------------------------------------------------
package blood_alarm_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam int unsigned PH_W   = 4;
    localparam int unsigned TYPE_W = 3;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/blood_alarm_controller_streak.sv
// -----------------------------------------------------------------------------
// sample_streak_counter
// Counts consecutive qualifying samples. Clear has priority over increment.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - return count to zero
//   inc        - count one more qualifying sample
//   cmp_val    - terminal value
//   hit        - this increment brings the count to cmp_val
// -----------------------------------------------------------------------------
module sample_streak_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic         hit
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // Flag is raised by the increment itself so the owner can act on the
    // same edge that would store the terminal value.
    assign hit = inc && ((count_q + W'(1)) == cmp_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/blood_alarm_controller.sv
// -----------------------------------------------------------------------------
// blood_alarm_controller
// Confirms a blood fault after CONFIRM_COUNT consecutive abnormal valid
// samples, raises a latched alarm with the confirming sample's pH/type, holds
// it until acknowledged and then ignores input for HOLDOFF_CYCLES cycles.
// Optional: define BLOOD_ALARM_AUTOCLEAR_EN to also clear the alarm after
// AUTOCLEAR_SAMPLES consecutive valid normal samples.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   sample_valid       - new sample strobe
//   blood_abnormality  - abnormality flag of the sample
//   blood_ph/type      - sample pH and type codes
//   alarm_ack          - operator acknowledge (level)
//   alarm              - latched alarm
//   alarm_ph/type      - captured pH/type of the confirming sample
//   event_count        - saturating count of alarms raised
//   state              - FSM state encoding (debug)
// -----------------------------------------------------------------------------
module blood_alarm_controller
    import blood_alarm_pkg::*;
#(
    parameter int unsigned CONFIRM_COUNT     = 3,
    parameter int unsigned HOLDOFF_CYCLES    = 16,
    parameter int unsigned EVT_W             = 8,
    parameter int unsigned AUTOCLEAR_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic              blood_abnormality,
    input  logic [PH_W-1:0]   blood_ph,
    input  logic [TYPE_W-1:0] blood_type,
    input  logic              alarm_ack,
    output logic              alarm,
    output logic [PH_W-1:0]   alarm_ph,
    output logic [TYPE_W-1:0] alarm_type,
    output logic [EVT_W-1:0]  event_count,
    output logic [1:0]        state
);

    localparam int unsigned HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HO_W-1:0]   hold_q, hold_d;
    logic              alarm_q, alarm_d;
    logic [PH_W-1:0]   alarm_ph_q, alarm_ph_d;
    logic [TYPE_W-1:0] alarm_type_q, alarm_type_d;
    logic [EVT_W-1:0]  event_count_q, event_count_d;

    logic sample_abn, sample_norm, watching;
    logic streak_inc, streak_clr, confirm;
    logic autoclear;

    assign sample_abn  = sample_valid & blood_abnormality;
    assign sample_norm = sample_valid & ~blood_abnormality;
    assign watching    = (state_q == NORMAL) || (state_q == SUSPECT);

    // Abnormal streak; a hit is the confirming sample (covers CONFIRM_COUNT==1
    // straight from NORMAL).
    assign streak_inc = watching & sample_abn;
    assign streak_clr = (watching & sample_norm) | confirm;

    sample_streak_counter #(
        .W(4)
    ) u_abn_streak (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (streak_clr),
        .inc     (streak_inc),
        .cmp_val (4'(CONFIRM_COUNT)),
        .hit     (confirm)
    );

`ifdef BLOOD_ALARM_AUTOCLEAR_EN
    localparam int unsigned AC_W = $clog2(AUTOCLEAR_SAMPLES + 1);

    logic ac_inc, ac_clr;

    assign ac_inc = (state_q == ALARM) & sample_norm;
    assign ac_clr = (state_q != ALARM) | sample_abn;

    sample_streak_counter #(
        .W(AC_W)
    ) u_autoclear_streak (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ac_clr),
        .inc     (ac_inc),
        .cmp_val (AC_W'(AUTOCLEAR_SAMPLES)),
        .hit     (autoclear)
    );
`else
    assign autoclear = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            NORMAL, SUSPECT: begin
                if (confirm) begin
                    state_d = ALARM;
                end else if (sample_abn) begin
                    state_d = SUSPECT;
                end else if (sample_norm) begin
                    state_d = NORMAL;
                end
            end
            ALARM: begin
                if (alarm_ack || autoclear) begin
                    state_d = HOLDOFF;
                    hold_d  = HO_LOAD;
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = NORMAL;
                end else begin
                    hold_d = hold_q - HO_W'(1);
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Output logic (registered below)
    always_comb begin
        alarm_d       = (state_d == ALARM);
        alarm_ph_d    = alarm_ph_q;
        alarm_type_d  = alarm_type_q;
        event_count_d = event_count_q;
        if (confirm) begin
            alarm_ph_d    = blood_ph;
            alarm_type_d  = blood_type;
            event_count_d = EVT_W'(sat_inc(32'(event_count_q), EVT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q       <= 1'b0;
            alarm_ph_q    <= '0;
            alarm_type_q  <= '0;
            event_count_q <= '0;
        end else begin
            alarm_q       <= alarm_d;
            alarm_ph_q    <= alarm_ph_d;
            alarm_type_q  <= alarm_type_d;
            event_count_q <= event_count_d;
        end
    end

    assign alarm       = alarm_q;
    assign alarm_ph    = alarm_ph_q;
    assign alarm_type  = alarm_type_q;
    assign event_count = event_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_blood_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_blood_alarm_controller
// Directed and random stimulus for blood_alarm_controller, compared every
// cycle against a behavioural model of the alarm rules.
// -----------------------------------------------------------------------------
module tb_blood_alarm_controller;

    localparam int CONF  = 3;
    localparam int HOLD  = 16;
    localparam int EVT_W = 8;
    localparam int ACN   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sample_valid;
    logic             blood_abnormality;
    logic [3:0]       blood_ph;
    logic [2:0]       blood_type;
    logic             alarm_ack;
    logic             alarm;
    logic [3:0]       alarm_ph;
    logic [2:0]       alarm_type;
    logic [EVT_W-1:0] event_count;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0=normal 1=suspect 2=alarm 3=holdoff
    int m_mode, m_run, m_left, m_alarm, m_ph, m_ty, m_evt, m_ac;

    always #5 clk = ~clk;

    blood_alarm_controller #(
        .CONFIRM_COUNT     (CONF),
        .HOLDOFF_CYCLES    (HOLD),
        .EVT_W             (EVT_W),
        .AUTOCLEAR_SAMPLES (ACN)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sample_valid      (sample_valid),
        .blood_abnormality (blood_abnormality),
        .blood_ph          (blood_ph),
        .blood_type        (blood_type),
        .alarm_ack         (alarm_ack),
        .alarm             (alarm),
        .alarm_ph          (alarm_ph),
        .alarm_type        (alarm_type),
        .event_count       (event_count),
        .state             (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), m_mode);
        chk("alarm", 32'(alarm), m_alarm);
        chk("alarm_ph", 32'(alarm_ph), m_ph);
        chk("alarm_type", 32'(alarm_type), m_ty);
        chk("event_count", 32'(event_count), m_evt);
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_left = 0; m_alarm = 0;
        m_ph = 0; m_ty = 0; m_evt = 0; m_ac = 0;
    endtask

    task automatic model_step(input int v, input int abn, input int ph, input int ty, input int ack);
        int clear_it;
        case (m_mode)
            0, 1: begin
                if (v != 0) begin
                    if (abn != 0) begin
                        m_run++;
                        if (m_run >= CONF) begin
                            m_mode = 2; m_alarm = 1; m_ph = ph; m_ty = ty;
                            m_evt = (m_evt < (1 << EVT_W) - 1) ? m_evt + 1 : m_evt;
                            m_run = 0; m_ac = 0;
                        end else begin
                            m_mode = 1;
                        end
                    end else begin
                        m_run = 0; m_mode = 0;
                    end
                end
            end
            2: begin
                clear_it = ack;
`ifdef BLOOD_ALARM_AUTOCLEAR_EN
                if (v != 0) m_ac = (abn != 0) ? 0 : m_ac + 1;
                if (m_ac >= ACN) clear_it = 1;
`endif
                if (clear_it != 0) begin
                    m_mode = 3; m_alarm = 0; m_left = HOLD; m_ac = 0;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        endcase
    endtask

    // One clock: drive at the falling edge, model on the rising edge,
    // compare at the next falling edge.
    task automatic step(input int v, input int abn, input int ph, input int ty, input int ack);
        sample_valid      = 1'(v);
        blood_abnormality = 1'(abn);
        blood_ph          = 4'(ph);
        blood_type        = 3'(ty);
        alarm_ack         = 1'(ack);
        @(posedge clk);
        model_step(v, abn, ph, ty, ack);
        @(negedge clk);
        check_all();
    endtask

    task automatic to_normal();
        for (int i = 0; i < 60 && state != 2'd0; i++)
            step(0, 0, 0, 0, (state == 2'd2) ? 1 : 0);
        chk("to_normal_timeout", 32'(state), 0);
    endtask

    task automatic raise_alarm(input int ph, input int ty);
        for (int i = 0; i < CONF; i++) step(1, 1, ph, ty, 0);
    endtask

    initial begin
        int dwell;
        rst_n = 1'b0;
        sample_valid = 0; blood_abnormality = 0; blood_ph = 0; blood_type = 0; alarm_ack = 0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Three abnormal samples raise the alarm with the last sample's data
        step(1, 1, 3, 5, 0);
        step(1, 1, 2, 6, 1);   // ack outside ALARM is ignored
        step(1, 1, 7, 1, 1);   // ack with the confirming sample is ignored
        chk("t1_alarm", 32'(alarm), 1);
        chk("t1_ph", 32'(alarm_ph), 7);

        // Acknowledge and measure the hold-off dwell while sending abnormals
        step(0, 0, 0, 0, 1);
        dwell = 0;
        for (int i = 0; i < 40 && state == 2'd3; i++) begin
            dwell++;
            step(1, 1, int'($urandom_range(15)), int'($urandom_range(7)), 1);
        end
        chk("holdoff_dwell", 32'(dwell), HOLD);
        chk("t1_ph_persist", 32'(alarm_ph), 7);

        // Abnormal, abnormal, normal, abnormal: back to NORMAL then SUSPECT
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0);

        // Idle gaps keep the streak
        step(1, 1, 9, 2, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 10, 3, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 11, 4, 0);
        chk("gap_alarm", 32'(alarm), 1);
        to_normal();

        // Bring event_count to 5 while in ALARM, then reset asynchronously
        for (int i = 0; i < 10 && m_evt < 5; i++) begin
            raise_alarm(i + 4, i);
            if (m_evt < 5) to_normal();
        end
        chk("evt_before_reset", 32'(event_count), 5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BLOOD_ALARM_AUTOCLEAR_EN
        // 7 normal, 1 abnormal, 8 normal: only the last run clears the alarm
        raise_alarm(12, 6);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        chk("ac_still_alarm", 32'(alarm), 1);
        step(1, 0, 0, 0, 0);
        chk("ac_holdoff", 32'(state), 3);
        to_normal();
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(3) != 0) ? 1 : 0, ($urandom_range(4) != 0) ? 1 : 0,
                 int'($urandom_range(15)), int'($urandom_range(7)),
                 ($urandom_range(7) == 0) ? 1 : 0);
        end

        // Saturate the event counter
        to_normal();
        for (int i = 0; i < 270 && m_evt < (1 << EVT_W) - 1; i++) begin
            raise_alarm(i % 16, i % 8);
            to_normal();
        end
        raise_alarm(5, 5);
        chk("evt_saturated", 32'(event_count), (1 << EVT_W) - 1);
        to_normal();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
